data_mem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage load/store requests.
- Accepts one word-sized read or write over a valid/ready handshake and services it after a fixed, parameterised latency.
- Returns a single-cycle response (read data or write acknowledge), with an error flag for misaligned addresses.
- Drives a busy flag the hazard logic uses to freeze the pipeline while an access is in flight.

---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder_mem_array.sv | 27 ++
 rtl/data_mem_responder.sv | 131 +++++++++++++
 tb/tb_data_mem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFS_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word accesses must have a zero byte offset.
  function automatic logic is_misaligned(input logic [BYTE_OFS_W-1:0] ofs);
    return (ofs != {BYTE_OFS_W{1'b0}});
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the responder (slave).
interface data_mem_responder_if;

  logic                        req_valid;
  logic                        req_write;
  logic [mem_pkg::WORD_W-1:0]  req_addr;
  logic [mem_pkg::WORD_W-1:0]  req_wdata;
  logic                        req_ready;
  logic                        resp_valid;
  logic [mem_pkg::WORD_W-1:0]  resp_rdata;
  logic                        resp_err;
  logic                        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Single-port synchronous RAM, DEPTH x WORD_W, with a registered read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [WORD_W-1:0]        wdata_i,
  output logic [WORD_W-1:0]        rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Storage is deliberately left unreset; read returns the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder for the MEM stage; one request in flight at a time.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW    = IDX_W + BYTE_OFS_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;

  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic               rdata_sel_q, rdata_sel_d;

  logic               access_s;
  logic               misaligned_s;
  logic               mem_we_s;
  logic [IDX_W-1:0]   mem_idx_s;
  logic [WORD_W-1:0]  mem_rdata_s;
  logic               unused_addr_s;

  assign access_s      = (state_q == BUSY) && (cnt_q == CNT_ZERO);
  assign misaligned_s  = is_misaligned(addr_q[BYTE_OFS_W-1:0]);
  assign mem_idx_s     = addr_q[AW-1:BYTE_OFS_W];
  // Reset wins over a store landing on the same edge.
  assign mem_we_s      = access_s && write_q && !misaligned_s && !rst;
  assign unused_addr_s = ^bus.req_addr[WORD_W-1:AW];

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          write_d = bus.req_write;
          addr_d  = bus.req_addr[AW-1:0];
          wdata_d = bus.req_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = resp_valid_d && misaligned_s;
    rdata_sel_d  = resp_valid_d && !write_q && !misaligned_s;
  end

  // State, request latch and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      write_q      <= 1'b0;
      addr_q       <= {AW{1'b0}};
      wdata_q      <= {WORD_W{1'b0}};
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_sel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_sel_q  <= rdata_sel_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we_s),
    .idx_i   (mem_idx_s),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata_s)
  );

  // The RAM read register is only meaningful during a clean load response.
  assign bus.resp_rdata = rdata_sel_q ? mem_rdata_s : {WORD_W{1'b0}};
  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input int sel, input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      if0.req_valid = v; if0.req_write = w; if0.req_addr = a; if0.req_wdata = d;
    end else begin
      if1.req_valid = v; if1.req_write = w; if1.req_addr = a; if1.req_wdata = d;
    end
  endtask

  function automatic logic g_rv(input int sel);
    return (sel == 0) ? if0.resp_valid : if1.resp_valid;
  endfunction
  function automatic logic g_busy(input int sel);
    return (sel == 0) ? if0.busy : if1.busy;
  endfunction
  function automatic logic g_rdy(input int sel);
    return (sel == 0) ? if0.req_ready : if1.req_ready;
  endfunction
  function automatic logic g_err(input int sel);
    return (sel == 0) ? if0.resp_err : if1.resp_err;
  endfunction
  function automatic logic [31:0] g_rd(input int sel);
    return (sel == 0) ? if0.resp_rdata : if1.resp_rdata;
  endfunction

  // Issue one request and collect latency, busy length, response fields and post-response idle state.
  task automatic do_req(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int bcnt, output logic [31:0] rdata,
                        output logic err, output logic idle_ok);
    int guard;
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    guard = 0;
    while (g_rdy(sel) !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    lat  = 0;
    bcnt = (g_busy(sel) === 1'b1) ? 1 : 0;
    while (g_rv(sel) !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (g_busy(sel) === 1'b1) bcnt++;
    end
    rdata = g_rd(sel);
    err   = g_err(sel);
    @(posedge clk); #1;
    idle_ok = (g_rdy(sel) === 1'b1) && (g_rv(sel) === 1'b0) && (g_busy(sel) === 1'b0) &&
              (g_rd(sel) === 32'h0) && (g_err(sel) === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (if0.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", if0.req_ready); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", if0.busy); end
    total++; if (if0.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", if0.resp_valid); end
    total++; if (if0.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", if0.resp_rdata); end
    total++; if (if0.resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", if0.resp_err); end
    total++; if (if1.busy !== 1'b0 || if1.req_ready !== 1'b1) begin bad++; $display("FAIL reset_l1 busy=%b ready=%b exp 0/1", if1.busy, if1.req_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    int lat, bcnt; logic [31:0] rd; logic err, idle;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, bcnt, rd, err, idle);
    total++; if (lat != 2) begin bad++; $display("FAIL st_latency got=%0d exp=2", lat); end
    total++; if (bcnt != 3) begin bad++; $display("FAIL st_busy_len got=%0d exp=3", bcnt); end
    total++; if (rd !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL st_resp rdata=%h err=%b exp 0/0", rd, err); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL st_idle got=%b exp=1", idle); end
    do_req(0, 1'b0, 32'h10, 32'h0, lat, bcnt, rd, err, idle);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_data got=%h exp=deadbeef", rd); end
    total++; if (lat != 2 || err !== 1'b0) begin bad++; $display("FAIL ld_lat_err lat=%0d err=%b exp 2/0", lat, err); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL ld_idle got=%b exp=1", idle); end
  endtask

  task automatic test_alias();
    int lat, bcnt; logic [31:0] rd; logic err, idle;
    do_req(0, 1'b1, 32'h04, 32'h11111111, lat, bcnt, rd, err, idle);
    do_req(0, 1'b0, 32'h04 + DEPTH * 4, 32'h0, lat, bcnt, rd, err, idle);
    total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL alias_data got=%h exp=11111111", rd); end
    do_req(0, 1'b0, 32'hFFFF_0010, 32'h0, lat, bcnt, rd, err, idle);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL alias_high got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_misaligned();
    int lat, bcnt; logic [31:0] rd; logic err, idle;
    do_req(0, 1'b0, 32'h13, 32'h0, lat, bcnt, rd, err, idle);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_ld_err got=%b exp=1", err); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_ld_rdata got=%h exp=0", rd); end
    total++; if (lat != 2 || idle !== 1'b1) begin bad++; $display("FAIL mis_ld_timing lat=%0d idle=%b exp 2/1", lat, idle); end
    do_req(0, 1'b1, 32'h11, 32'h55555555, lat, bcnt, rd, err, idle);
    total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_st_resp err=%b rdata=%h exp 1/0", err, rd); end
    do_req(0, 1'b0, 32'h10, 32'h0, lat, bcnt, rd, err, idle);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL mis_no_write got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, busy_cnt, got;
    logic [31:0] rd, gd; logic err, idle;
    int acc[$];
    logic [31:0] rds[$];
    int exp_acc[3] = '{0, 4, 8};
    for (int k = 0; k < 12; k++) begin
      do_req(0, 1'b1, 32'(32'h40 + 4 * k), 32'(32'hA5A5_0000 + k), lat, bcnt, rd, err, idle);
    end
    busy_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c <= 10) drive(0, 1'b1, 1'b0, 32'(32'h40 + 4 * c), 32'h0);
      else         drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (c <= 10 && if0.req_ready === 1'b1) acc.push_back(c);
      @(posedge clk); #1;
      if (if0.busy === 1'b1) busy_cnt++;
      if (if0.resp_valid === 1'b1) rds.push_back(if0.resp_rdata);
    end
    total++; if (acc.size() != 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", acc.size()); end
    total++; if (rds.size() != 3) begin bad++; $display("FAIL b2b_responses got=%0d exp=3", rds.size()); end
    total++; if (busy_cnt != 9) begin bad++; $display("FAIL b2b_busy got=%0d exp=9", busy_cnt); end
    for (int i = 0; i < 3; i++) begin
      got = (i < acc.size()) ? acc[i] : -1;
      gd  = (i < rds.size()) ? rds[i] : 32'hXXXX_XXXX;
      total++; if (got != exp_acc[i]) begin bad++; $display("FAIL b2b_accept_cycle[%0d] got=%0d exp=%0d", i, got, exp_acc[i]); end
      total++; if (gd !== 32'(32'hA5A5_0000 + exp_acc[i])) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, gd, 32'(32'hA5A5_0000 + exp_acc[i])); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, rv_seen; logic [31:0] rd; logic err, idle;
    do_req(0, 1'b1, 32'h20, 32'h0, lat, bcnt, rd, err, idle);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (if0.busy !== 1'b1) begin bad++; $display("FAIL rmid_accept busy=%b exp=1", if0.busy); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (if0.busy !== 1'b0 || if0.req_ready !== 1'b1 || if0.resp_valid !== 1'b0 ||
                 if0.resp_rdata !== 32'h0 || if0.resp_err !== 1'b0) begin
      bad++; $display("FAIL rmid_outputs busy=%b ready=%b rv=%b rdata=%h err=%b exp 0/1/0/0/0",
                      if0.busy, if0.req_ready, if0.resp_valid, if0.resp_rdata, if0.resp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (if0.resp_valid === 1'b1) rv_seen++;
    end
    total++; if (rv_seen != 0) begin bad++; $display("FAIL rmid_no_resp got=%0d exp=0", rv_seen); end
    do_req(0, 1'b0, 32'h20, 32'h0, lat, bcnt, rd, err, idle);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rmid_dropped got=%h exp=0", rd); end
  endtask

  task automatic test_latency1();
    int lat, bcnt; logic [31:0] rd; logic err, idle;
    do_req(1, 1'b1, 32'h08, 32'h0BADC0DE, lat, bcnt, rd, err, idle);
    total++; if (lat != 1) begin bad++; $display("FAIL l1_st_latency got=%0d exp=1", lat); end
    total++; if (bcnt != 2) begin bad++; $display("FAIL l1_busy_len got=%0d exp=2", bcnt); end
    do_req(1, 1'b0, 32'h08, 32'h0, lat, bcnt, rd, err, idle);
    total++; if (rd !== 32'h0BADC0DE || err !== 1'b0) begin bad++; $display("FAIL l1_ld_data got=%h err=%b exp=0badc0de/0", rd, err); end
    total++; if (lat != 1 || idle !== 1'b1) begin bad++; $display("FAIL l1_ld_timing lat=%0d idle=%b exp 1/1", lat, idle); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alias();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
